// File: rtl/relu_sched.sv
// Sequencer streaming a packed 4-lane feature buffer through the 4-lane ReLU datapath
// into a destination buffer, with clamp counting and a datapath-handshake error flag.
module relu_sched #(
  parameter int RELU_SIZE = 5,
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   hold,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [4*RELU_SIZE-1:0] rd_data,
  output logic                   relu_in_ready,
  output logic [RELU_SIZE-1:0]   relu_in0,
  output logic [RELU_SIZE-1:0]   relu_in1,
  output logic [RELU_SIZE-1:0]   relu_in2,
  output logic [RELU_SIZE-1:0]   relu_in3,
  input  logic [RELU_SIZE-1:0]   relu_out0,
  input  logic [RELU_SIZE-1:0]   relu_out1,
  input  logic [RELU_SIZE-1:0]   relu_out2,
  input  logic [RELU_SIZE-1:0]   relu_out3,
  input  logic                   relu_ready,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [4*RELU_SIZE-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W+2:0]      clamp_count,
  output logic                   err
);

  // state | meaning
  // IDLE  | waiting for start; done pulses here for one cycle after a pass
  // ISSUE | one source read per cycle unless hold is high
  // DRAIN | reads finished, waiting for the last word to be written
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam int CW = ADDR_W + 3;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              s1_valid;
  logic              s2_valid;
  logic [ADDR_W-1:0] s1_tag;
  logic [ADDR_W-1:0] s2_tag;
  logic [2:0]        neg_lanes;
  logic [CW:0]       clamp_sum;

  // The read strobe reacts to hold in the same cycle so a held cycle issues nothing.
  assign rd_en   = (state == ISSUE) && !hold;
  assign rd_addr = addr;

  // rd_data comes from a registered memory port, so it lines up with stage-1 valid.
  assign relu_in_ready = s1_valid;
  assign relu_in0 = s1_valid ? rd_data[0*RELU_SIZE +: RELU_SIZE] : '0;
  assign relu_in1 = s1_valid ? rd_data[1*RELU_SIZE +: RELU_SIZE] : '0;
  assign relu_in2 = s1_valid ? rd_data[2*RELU_SIZE +: RELU_SIZE] : '0;
  assign relu_in3 = s1_valid ? rd_data[3*RELU_SIZE +: RELU_SIZE] : '0;

  assign wr_en   = s2_valid;
  assign wr_addr = s2_tag;
  assign wr_data = s2_valid ? {relu_out3, relu_out2, relu_out1, relu_out0} : '0;

  always_comb begin
    neg_lanes = 3'(rd_data[1*RELU_SIZE-1]) + 3'(rd_data[2*RELU_SIZE-1])
              + 3'(rd_data[3*RELU_SIZE-1]) + 3'(rd_data[4*RELU_SIZE-1]);
    clamp_sum = {1'b0, clamp_count} + (CW+1)'(neg_lanes);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s1_tag      <= '0;
      s2_tag      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      clamp_count <= '0;
    end else begin
      done     <= 1'b0;
      s1_valid <= rd_en;
      s1_tag   <= addr;
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      if (s1_valid)
        clamp_count <= clamp_sum[CW] ? '1 : clamp_sum[CW-1:0];
      if (busy && (relu_ready != s2_valid))
        err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            addr        <= '0;
            clamp_count <= '0;
            err         <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ISSUE: begin
          if (!hold) begin
            addr <= addr + 1'b1;
            if (addr == LAST)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (s2_valid && (s2_tag == LAST)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
